// File: rtl/dma_bus_arbiter.sv
// Two-requester arbiter sharing one simple read/write memory master port.
// Grants whole transactions, round-robin or fixed priority, with a per-transaction watchdog.
module dma_bus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_R_req,
  input  logic        m1_R_req,
  input  logic [31:0] m0_AR_ADDR,
  input  logic [31:0] m1_AR_ADDR,
  output logic [31:0] m0_R_DATA,
  output logic [31:0] m1_R_DATA,
  output logic        m0_R_valid,
  output logic        m1_R_valid,
  input  logic        m0_W_req,
  input  logic        m1_W_req,
  input  logic [31:0] m0_AW_ADDR,
  input  logic [31:0] m1_AW_ADDR,
  input  logic [31:0] m0_W_DATA,
  input  logic [31:0] m1_W_DATA,
  output logic        m0_W_done,
  output logic        m1_W_done,
  output logic        m0_err,
  output logic        m1_err,
  output logic        s_R_req,
  output logic [31:0] s_AR_ADDR,
  input  logic [31:0] s_R_DATA,
  input  logic        s_R_valid,
  output logic        s_W_req,
  output logic [31:0] s_AW_ADDR,
  output logic [31:0] s_W_DATA,
  input  logic        s_W_done,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_owner;
  logic        r_op;
  logic        r_last_owner;
  logic [15:0] r_tmo_cnt;

  logic w_busy, w_v0, w_v1, w_pick1;
  logic w_own_rreq, w_own_wreq, w_own_req;
  logic w_done, w_tmo_hit, w_err;

  assign w_busy     = (r_state == BUSY);
  assign w_v0       = m0_R_req | m0_W_req;
  assign w_v1       = m1_R_req | m1_W_req;
  // m1 wins when alone, or on a round-robin tie when m0 held the bus last
  assign w_pick1    = w_v1 & (~w_v0 | ((FIXED_PRIO == 0) & ~r_last_owner));

  assign w_own_rreq = r_owner ? m1_R_req : m0_R_req;
  assign w_own_wreq = r_owner ? m1_W_req : m0_W_req;
  assign w_own_req  = r_op ? w_own_wreq : w_own_rreq;
  assign w_done     = w_busy & (r_op ? s_W_done : s_R_valid);
  assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);
  // a completion or a cancel in the expiry cycle suppresses the abort pulse
  assign w_err      = w_busy & w_own_req & ~w_done & w_tmo_hit;

  assign m0_R_DATA = s_R_DATA;
  assign m1_R_DATA = s_R_DATA;

  always_comb begin
    s_R_req    = 1'b0;
    s_AR_ADDR  = '0;
    s_W_req    = 1'b0;
    s_AW_ADDR  = '0;
    s_W_DATA   = '0;
    m0_R_valid = 1'b0;
    m1_R_valid = 1'b0;
    m0_W_done  = 1'b0;
    m1_W_done  = 1'b0;
    m0_err     = 1'b0;
    m1_err     = 1'b0;
    grant      = '0;
    busy       = w_busy;
    if (w_busy) begin
      grant = r_owner ? 2'b10 : 2'b01;
      if (r_op) begin
        s_W_req   = w_own_wreq;
        s_AW_ADDR = r_owner ? m1_AW_ADDR : m0_AW_ADDR;
        s_W_DATA  = r_owner ? m1_W_DATA : m0_W_DATA;
        m0_W_done = w_done & ~r_owner;
        m1_W_done = w_done & r_owner;
      end else begin
        s_R_req    = w_own_rreq;
        s_AR_ADDR  = r_owner ? m1_AR_ADDR : m0_AR_ADDR;
        m0_R_valid = w_done & ~r_owner;
        m1_R_valid = w_done & r_owner;
      end
      m0_err = w_err & ~r_owner;
      m1_err = w_err & r_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_op         <= 1'b0;
      r_last_owner <= 1'b1;
      r_tmo_cnt    <= '0;
    end else if (r_state == IDLE) begin
      if (w_v0 | w_v1) begin
        r_owner   <= w_pick1;
        r_op      <= w_pick1 ? m1_W_req : m0_W_req;
        r_tmo_cnt <= '0;
        r_state   <= BUSY;
      end
    end else begin
      if (w_done | ~w_own_req | w_tmo_hit) begin
        r_state      <= IDLE;
        r_last_owner <= r_owner;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: round-robin and fixed-priority instances share stimulus and are
// compared every cycle against a transaction-level model, plus table and directed sequences.
module tb_dma_bus_arbiter;

  localparam int TMO = 8;

  typedef struct packed {
    logic        sr;
    logic [31:0] ar;
    logic        sw;
    logic [31:0] aw;
    logic [31:0] wd;
    logic [1:0]  gnt;
    logic        bsy;
    logic [1:0]  rv;
    logic [1:0]  wdn;
    logic [1:0]  er;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } outs_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       rq, wq;
  logic [1:0][31:0] ar, aw, wd;
  logic [31:0]      s_rdata;
  logic             s_rvalid, s_wdone;

  outs_t act [2];

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        sr, sw, bsy, rv0, rv1, wd0, wd1, er0, er1;
    logic [31:0] sar, saw, swd, rd0, rd1;
    logic [1:0]  gnt;
    dma_bus_arbiter #(.FIXED_PRIO(g), .TIMEOUT(TMO)) u_dut (
      .clk(clk), .rst(rst),
      .m0_R_req(rq[0]), .m1_R_req(rq[1]),
      .m0_AR_ADDR(ar[0]), .m1_AR_ADDR(ar[1]),
      .m0_R_DATA(rd0), .m1_R_DATA(rd1),
      .m0_R_valid(rv0), .m1_R_valid(rv1),
      .m0_W_req(wq[0]), .m1_W_req(wq[1]),
      .m0_AW_ADDR(aw[0]), .m1_AW_ADDR(aw[1]),
      .m0_W_DATA(wd[0]), .m1_W_DATA(wd[1]),
      .m0_W_done(wd0), .m1_W_done(wd1),
      .m0_err(er0), .m1_err(er1),
      .s_R_req(sr), .s_AR_ADDR(sar), .s_R_DATA(s_rdata), .s_R_valid(s_rvalid),
      .s_W_req(sw), .s_AW_ADDR(saw), .s_W_DATA(swd), .s_W_done(s_wdone),
      .grant(gnt), .busy(bsy)
    );
    assign act[g] = '{sr: sr, ar: sar, sw: sw, aw: saw, wd: swd, gnt: gnt, bsy: bsy,
                      rv: {rv1, rv0}, wdn: {wd1, wd0}, er: {er1, er0}, rd0: rd0, rd1: rd1};
  end

  // Transaction-level reference: who holds the bus, which kind of transfer, and how long.
  bit m_busy [2];
  int m_own  [2];
  bit m_wr   [2];
  int m_last [2];
  int m_age  [2];

  function automatic bit owner_still_wants(int d);
    return m_wr[d] ? wq[m_own[d]] : rq[m_own[d]];
  endfunction

  function automatic outs_t expected(int d);
    outs_t o;
    int    w;
    bit    resp;
    o = '0;
    o.rd0 = s_rdata;
    o.rd1 = s_rdata;
    if (m_busy[d]) begin
      w     = m_own[d];
      o.bsy = 1'b1;
      o.gnt[w] = 1'b1;
      resp  = m_wr[d] ? s_wdone : s_rvalid;
      if (m_wr[d]) begin
        o.sw = wq[w]; o.aw = aw[w]; o.wd = wd[w];
        o.wdn[w] = resp;
      end else begin
        o.sr = rq[w]; o.ar = ar[w];
        o.rv[w] = resp;
      end
      if (!resp && owner_still_wants(d) && m_age[d] == TMO - 1) o.er[w] = 1'b1;
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_own[d] = 0; m_wr[d] = 0; m_last[d] = 1; m_age[d] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 0; m_own[d] = 0; m_wr[d] = 0; m_last[d] = 1; m_age[d] = 0;
      end else if (!m_busy[d]) begin
        if ((rq | wq) != 2'b00) begin
          if ((rq | wq) == 2'b11) m_own[d] = (d == 1) ? 0 : 1 - m_last[d];
          else                     m_own[d] = (rq[1] | wq[1]) ? 1 : 0;
          m_wr[d]   = wq[m_own[d]];
          m_age[d]  = 0;
          m_busy[d] = 1;
        end
      end else if ((m_wr[d] ? s_wdone : s_rvalid) || !owner_still_wants(d) ||
                   m_age[d] == TMO - 1) begin
        m_busy[d] = 0;
        m_last[d] = m_own[d];
      end else begin
        m_age[d]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        outs_t e;
        e = expected(d);
        nchk++;
        if (act[d] !== e) begin
          nerr++;
          $display("FAIL model_dut%0d t=%0t actual=%h required=%h", d, $time, act[d], e);
        end
      end
    end
  end

  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rq = '0; wq = '0; ar = '0; aw = '0; wd = '0;
    s_rvalid = 1'b0; s_wdone = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  typedef struct {
    logic [1:0] rq, wq;
    logic [1:0] g_rr, g_fp;
    logic       sr, sw;
  } vec_t;

  vec_t vecs [9];

  initial begin
    model_reset();
    s_rdata = 32'h5A5A_0001;
    vecs[0] = '{rq: 2'b00, wq: 2'b00, g_rr: 2'b00, g_fp: 2'b00, sr: 0, sw: 0};
    vecs[1] = '{rq: 2'b01, wq: 2'b00, g_rr: 2'b01, g_fp: 2'b01, sr: 1, sw: 0};
    vecs[2] = '{rq: 2'b00, wq: 2'b01, g_rr: 2'b01, g_fp: 2'b01, sr: 0, sw: 1};
    vecs[3] = '{rq: 2'b01, wq: 2'b01, g_rr: 2'b01, g_fp: 2'b01, sr: 0, sw: 1};
    vecs[4] = '{rq: 2'b10, wq: 2'b00, g_rr: 2'b10, g_fp: 2'b10, sr: 1, sw: 0};
    vecs[5] = '{rq: 2'b00, wq: 2'b10, g_rr: 2'b10, g_fp: 2'b10, sr: 0, sw: 1};
    vecs[6] = '{rq: 2'b11, wq: 2'b00, g_rr: 2'b01, g_fp: 2'b01, sr: 1, sw: 0};
    vecs[7] = '{rq: 2'b01, wq: 2'b10, g_rr: 2'b01, g_fp: 2'b01, sr: 1, sw: 0};
    vecs[8] = '{rq: 2'b10, wq: 2'b01, g_rr: 2'b01, g_fp: 2'b01, sr: 0, sw: 1};

    do_reset();
    @(negedge clk);
    chk("reset_outputs", 64'(act[0] ^ outs_t'({32'h0, 32'h0} | {s_rdata, s_rdata})), 64'h0);
    chk("reset_busy_grant", {61'h0, act[0].bsy, act[0].gnt}, 64'h0);

    // First-grant arbitration out of reset
    foreach (vecs[i]) begin
      do_reset();
      rq = vecs[i].rq; wq = vecs[i].wq;
      ar = {32'hA100_0000, 32'hA000_0000};
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_grant_rr", i), 64'(act[0].gnt), 64'(vecs[i].g_rr));
      chk($sformatf("vec%0d_grant_fp", i), 64'(act[1].gnt), 64'(vecs[i].g_fp));
      chk($sformatf("vec%0d_sreq", i), 64'({act[0].sr, act[0].sw}), 64'({vecs[i].sr, vecs[i].sw}));
    end

    // m1 write end to end
    do_reset();
    wq[1] = 1'b1; aw[1] = 32'h1000_0040; wd[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("m1w_idle_sw", 64'(act[0].sw), 64'h0);
    tick();
    @(negedge clk);
    chk("m1w_sw", 64'(act[0].sw), 64'h1);
    chk("m1w_addr_data", {act[0].aw, act[0].wd}, {32'h1000_0040, 32'hDEAD_BEEF});
    chk("m1w_grant", 64'(act[0].gnt), 64'h2);
    tick();
    s_wdone = 1'b1;
    @(negedge clk);
    chk("m1w_done", 64'(act[0].wdn), 64'h2);
    tick();
    s_wdone = 1'b0; wq[1] = 1'b0;
    @(negedge clk);
    chk("m1w_after_idle", {61'h0, act[0].bsy, act[0].gnt}, 64'h0);

    // Persistent tie: round-robin alternates, fixed priority always picks m0
    do_reset();
    rq = 2'b11; ar = {32'hB100_0010, 32'hB000_0020};
    for (int k = 0; k < 4; k++) begin
      tick();
      s_rvalid = 1'b1;
      @(negedge clk);
      chk($sformatf("tie%0d_grant_rr", k), 64'(act[0].gnt), (k % 2) ? 64'h2 : 64'h1);
      chk($sformatf("tie%0d_grant_fp", k), 64'(act[1].gnt), 64'h1);
      chk($sformatf("tie%0d_rvalid_rr", k), 64'(act[0].rv), (k % 2) ? 64'h2 : 64'h1);
      tick();
      s_rvalid = 1'b0;
      @(negedge clk);
      chk($sformatf("tie%0d_turnaround", k), 64'(act[0].gnt), 64'h0);
    end

    // Watchdog abort on an m1 read, then a late response is dropped
    do_reset();
    rq[1] = 1'b1; ar[1] = 32'hC000_0004;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      chk($sformatf("tmo_err_c%0d", c), 64'(act[0].er), (c == TMO) ? 64'h2 : 64'h0);
      if (c < TMO) tick();
    end
    tick();
    rq[1] = 1'b0;
    @(negedge clk);
    chk("tmo_idle", 64'(act[0].bsy), 64'h0);
    tick();
    s_rvalid = 1'b1;
    @(negedge clk);
    chk("tmo_late_rvalid", 64'(act[0].rv), 64'h0);
    tick();
    s_rvalid = 1'b0;

    // Same-master write before read
    do_reset();
    rq[0] = 1'b1; wq[0] = 1'b1; ar[0] = 32'hD000_0000; aw[0] = 32'hD000_0100;
    tick();
    s_wdone = 1'b1;
    @(negedge clk);
    chk("wr_first_req", 64'({act[0].sw, act[0].sr}), 64'h2);
    chk("wr_first_done", 64'(act[0].wdn), 64'h1);
    tick();
    s_wdone = 1'b0; wq[0] = 1'b0;
    @(negedge clk);
    chk("wr_turnaround", 64'(act[0].bsy), 64'h0);
    tick();
    @(negedge clk);
    chk("rd_second_req", 64'({act[0].sw, act[0].sr}), 64'h1);
    tick();
    s_rvalid = 1'b1;
    @(negedge clk);
    chk("rd_second_valid", 64'(act[0].rv), 64'h1);
    tick();
    s_rvalid = 1'b0; rq[0] = 1'b0;

    // Reset in the middle of an m1 read
    do_reset();
    rq[1] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; rq[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", {60'h0, act[0].bsy, act[0].gnt, act[0].sr}, 64'h0);
    tick();
    s_rvalid = 1'b1;
    @(negedge clk);
    chk("rst_late_rvalid", 64'(act[0].rv), 64'h0);
    tick();
    s_rvalid = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0) rq[m] = ~rq[m];
        if ($urandom_range(0, 9) == 0) wq[m] = ~wq[m];
        ar[m] = $urandom; aw[m] = $urandom; wd[m] = $urandom;
      end
      s_rdata  = $urandom;
      s_rvalid = ($urandom_range(0, 5) == 0);
      s_wdone  = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 199) == 0);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Shares one simple memory master port (read: R_req/AR_ADDR/R_DATA/R_valid; write: W_req/AW_ADDR/W_DATA/W_done) between two requesters.
- Requester m0 is the CPU data-side bridge; requester m1 is the DMA engine's master interface.
- Sits between the requesters and the AXI master wrapper. Grants whole transactions one at a time, with round-robin or fixed priority and a per-transaction watchdog timeout.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between m0/m1; 1 = m0 always wins a tie.
- TIMEOUT, 256: max cycles a granted transaction may stay in BUSY before abort (legal range 2..65535).

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- m0_R_req, m1_R_req  in  1  read request, level, held until response
- m0_AR_ADDR, m1_AR_ADDR  in  32  read address
- m0_R_DATA, m1_R_DATA  out  32  read data (both driven from s_R_DATA)
- m0_R_valid, m1_R_valid  out  1  one-cycle read-complete pulse to owner only
- m0_W_req, m1_W_req  in  1  write request, level
- m0_AW_ADDR, m1_AW_ADDR  in  32  write address
- m0_W_DATA, m1_W_DATA  in  32  write data
- m0_W_done, m1_W_done  out  1  one-cycle write-complete pulse to owner only
- m0_err, m1_err  out  1  one-cycle timeout-abort pulse to owner
- s_R_req  out  1  downstream read request
- s_AR_ADDR  out  32  downstream read address
- s_R_DATA  in  32  downstream read data
- s_R_valid  in  1  downstream read complete
- s_W_req  out  1  downstream write request
- s_AW_ADDR  out  32  downstream write address
- s_W_DATA  out  32  downstream write data
- s_W_done  in  1  downstream write complete
- grant  out  2  one-hot owner {m1,m0}; 2'b00 when idle
- busy  out  1  high in BUSY

Behaviour:
- State registers: state (IDLE, BUSY), owner (1 bit), op (0 = read, 1 = write), last_owner (1 bit), tmo_cnt (16 bits).
- Reset: state = IDLE, owner = 0, op = 0, last_owner = 1 (so m0 wins the first round-robin tie), tmo_cnt = 0.
- Outputs in reset/IDLE: all s_* requests, addresses and data = 0; all m*_R_valid, m*_W_done, m*_err = 0; grant = 0; busy = 0. m*_R_DATA is always s_R_DATA.
- IDLE, candidate per master: valid = R_req | W_req.
  - Within one master, a write takes precedence over a read (op = 1 if W_req is high).
  - Only one master requesting: it wins.
  - Both requesting, FIXED_PRIO = 1: m0 wins.
  - Both requesting, FIXED_PRIO = 0: the master that is not last_owner wins.
  - Winner is latched into owner/op, tmo_cnt cleared, next state BUSY.
  - Latency: request seen at edge N, s_* request asserted combinationally from edge N+1.
- BUSY, forwarding:
  - op = 0: s_R_req = owner R_req and s_AR_ADDR = owner AR_ADDR; s_W_req = 0.
  - op = 1: s_W_req, s_AW_ADDR, s_W_DATA forwarded from owner; s_R_req = 0.
  - Addresses and data are combinational muxes, so they track the owner live.
- BUSY, completion:
  - s_R_valid (op = 0) or s_W_done (op = 1) is passed combinationally as a same-cycle pulse to the owner only.
  - At that edge: next state IDLE, last_owner = owner.
  - The response type not matching op is ignored and never forwarded.
- BUSY, cancel: if the owner drops the latched req before completion, next state is IDLE. No err pulse; last_owner is updated.
- BUSY, timeout:
  - tmo_cnt increments each cycle.
  - If tmo_cnt == TIMEOUT-1 with no completion that cycle: owner err pulses for one cycle (combinational in that cycle), next state IDLE, last_owner = owner.
  - Completion in the same cycle as the timeout wins: no err.
- Turnaround: at least one IDLE cycle between transactions. A requester that keeps its req high re-arbitrates in that IDLE cycle.
- Responses arriving in IDLE (late, after abort or cancel) are dropped; no pulse to any master.
- The non-owner's requests are never forwarded and its pulses stay 0.
- rst asserted mid-BUSY: at the next edge, IDLE with all outputs 0. The outstanding downstream response is dropped per the IDLE rule.

Test Plan:
- m1 write: W_req = 1, AW_ADDR = 0x1000_0040, W_DATA = 0xDEAD_BEEF -> s_W_req high from the next cycle with the same addr/data; s_W_done pulse gives m1_W_done = 1 for one cycle, grant = 2'b10 during BUSY, IDLE the next cycle.
- m0 and m1 both raise R_req on the cycle after reset (FIXED_PRIO = 0) -> m0 served first; m1 served after one IDLE turnaround; third and fourth tie-breaks alternate m0, m1.
- FIXED_PRIO = 1, both requesting continuously -> m0 granted every transaction, m1 never granted.
- TIMEOUT = 8, m1 read with s_R_valid held 0 -> m1_err pulses in the 8th BUSY cycle, then IDLE. A later s_R_valid in IDLE produces no m*_R_valid.
- m0 raises R_req and W_req together -> write served first (s_W_req, s_R_req = 0); read served after W_done plus one IDLE cycle.
- rst asserted two cycles into an m1 read -> next edge: busy = 0, grant = 0, s_R_req = 0; s_R_valid one cycle later is ignored.
